// File: rtl/camera_capture_pkg.sv
// Shared tokens, FSM states and pixel format selectors for the OV7670 capture path.
package camera_capture_pkg;

    localparam logic [16:0] TOK_SOF   = 17'h10000;
    localparam logic [16:0] TOK_SOR   = 17'h10001;
    localparam logic [16:0] TOK_EOF   = 17'h1FFFF;
    localparam logic [16:0] TOK_ABORT = 17'h1FFFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ROW_START,
        ST_WAIT_HREF,
        ST_PIXEL,
        ST_ROW_END,
        ST_ABORT_PEND
    } state_t;

    typedef enum logic {
        FMT_RGB565 = 1'b0,
        FMT_Y8     = 1'b1
    } fmt_t;

endpackage

// File: rtl/camera_stream_capture_if.sv
// Sensor pins, frame-queue write port, control and status of the capture block.
interface camera_stream_capture_if #(
    parameter int CNT_W = 16
);
    logic             cam_vsync;
    logic             cam_href;
    logic [7:0]       p_data;
    logic             init_done;
    logic             fmt_mode;
    logic             queue_full;
    logic             clear_errors;
    logic             queue_clk;
    logic [16:0]      queue_data;
    logic             queue_wr_en;
    logic [CNT_W-1:0] frame_count;
    logic             err_overflow;
    logic             err_line;
    logic             err_frame;
    logic             busy;

    modport slave (
        input  cam_vsync, cam_href, p_data, init_done, fmt_mode, queue_full, clear_errors,
        output queue_clk, queue_data, queue_wr_en, frame_count, err_overflow, err_line,
               err_frame, busy
    );

    modport master (
        output cam_vsync, cam_href, p_data, init_done, fmt_mode, queue_full, clear_errors,
        input  queue_clk, queue_data, queue_wr_en, frame_count, err_overflow, err_line,
               err_frame, busy
    );
endinterface

// File: rtl/cam_byte_packer.sv
// Byte phase tracking and pixel word assembly; combinational word out, valid in the cycle the
// completing byte is presented. No backpressure: the FSM decides whether the word is written.
module cam_byte_packer
    import camera_capture_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_vld,
    input  logic [7:0]  i_byte,
    input  fmt_t        i_fmt,
    output logic [16:0] o_word,
    output logic        o_vld
);
    logic       r_phase;
    logic [7:0] r_hi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= 1'b0;
            r_hi    <= 8'h00;
        end else if (i_clr) begin
            r_phase <= 1'b0;
        end else if (i_vld) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_hi <= i_byte;
        end
    end

    // Y8 keeps the even (Y) byte of each YUYV pair; U/V bytes only advance the phase.
    always_comb begin
        if (i_fmt == FMT_Y8) begin
            o_vld  = i_vld & ~r_phase;
            o_word = {1'b0, 8'h00, i_byte};
        end else begin
            o_vld  = i_vld & r_phase;
            o_word = {1'b0, r_hi, i_byte};
        end
    end
endmodule

// File: rtl/camera_stream_capture.sv
// OV7670 capture into the frame queue: words strobe one cycle after their last byte/condition;
// a word presented while queue_full is held back, flagged as overflow and the frame aborted.
module camera_stream_capture
    import camera_capture_pkg::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int CNT_W        = 16
) (
    input  logic PixelClk,
    input  logic RST,
    camera_stream_capture_if.slave cap
);
    localparam int COL_W = $clog2(FRAME_WIDTH + 1) + 1;
    localparam int ROW_W = $clog2(FRAME_HEIGHT + 1) + 1;

    state_t           r_state, w_state_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    fmt_t             r_fmt, w_fmt_nxt;
    logic             r_q_vld, w_q_vld_nxt;
    logic [16:0]      r_q_dat, w_q_dat_nxt;
    logic             r_busy;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             r_err_ovf, r_err_line, r_err_frame;
    logic             w_set_ovf, w_set_line, w_set_frame;
    logic             w_wr_en, w_ovf, w_pk_clr, w_pk_in_vld, w_pk_vld;
    logic [16:0]      w_pk_word;

    assign w_wr_en     = r_q_vld & ~cap.queue_full;
    assign w_ovf       = r_q_vld & cap.queue_full & (r_state != ST_ABORT_PEND);
    assign w_pk_in_vld = cap.cam_href & ((r_state == ST_WAIT_HREF) || (r_state == ST_PIXEL));
    assign w_pk_clr    = (r_state == ST_ROW_START);

    cam_byte_packer u_packer (
        .i_clk  (PixelClk),
        .i_rst  (RST),
        .i_clr  (w_pk_clr),
        .i_vld  (w_pk_in_vld),
        .i_byte (cap.p_data),
        .i_fmt  (r_fmt),
        .o_word (w_pk_word),
        .o_vld  (w_pk_vld)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_fmt_nxt   = r_fmt;
        w_q_vld_nxt = 1'b0;
        w_q_dat_nxt = r_q_dat;
        w_set_ovf   = 1'b0;
        w_set_line  = 1'b0;
        w_set_frame = 1'b0;
        // A refused word overrides whatever the current state planned; a refused SOF just drops the frame.
        if (w_ovf) begin
            w_set_ovf = 1'b1;
            if (r_q_dat == TOK_SOF) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_ABORT_PEND;
                w_q_vld_nxt = 1'b1;
                w_q_dat_nxt = TOK_ABORT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cap.init_done && cap.cam_vsync) w_state_nxt = ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (!cap.cam_vsync) begin
                        w_q_vld_nxt = 1'b1;
                        w_q_dat_nxt = TOK_SOF;
                        w_fmt_nxt   = fmt_t'(cap.fmt_mode);
                        w_row_nxt   = '0;
                        w_state_nxt = ST_ROW_START;
                    end
                end
                ST_ROW_START: begin
                    w_q_vld_nxt = 1'b1;
                    w_q_dat_nxt = TOK_SOR;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_WAIT_HREF;
                end
                ST_WAIT_HREF: begin
                    if (cap.cam_vsync) begin
                        w_set_frame = 1'b1;
                        w_q_vld_nxt = 1'b1;
                        w_q_dat_nxt = TOK_ABORT;
                        w_state_nxt = ST_ABORT_PEND;
                    end else if (cap.cam_href) begin
                        if (w_pk_vld) begin
                            w_q_vld_nxt = 1'b1;
                            w_q_dat_nxt = w_pk_word;
                            w_col_nxt   = r_col + COL_W'(1);
                        end
                        w_state_nxt = ST_PIXEL;
                    end
                end
                ST_PIXEL: begin
                    if (cap.cam_href) begin
                        if (w_pk_vld && (r_col < COL_W'(FRAME_WIDTH))) begin
                            w_q_vld_nxt = 1'b1;
                            w_q_dat_nxt = w_pk_word;
                            w_col_nxt   = r_col + COL_W'(1);
                        end
                    end else if (r_col < COL_W'(FRAME_WIDTH)) begin
                        w_set_line  = 1'b1;
                        w_q_vld_nxt = 1'b1;
                        w_q_dat_nxt = TOK_ABORT;
                        w_state_nxt = ST_ABORT_PEND;
                    end else begin
                        w_state_nxt = ST_ROW_END;
                    end
                end
                ST_ROW_END: begin
                    if ((r_row + ROW_W'(1)) == ROW_W'(FRAME_HEIGHT)) begin
                        w_q_vld_nxt = 1'b1;
                        w_q_dat_nxt = TOK_EOF;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_row_nxt   = r_row + ROW_W'(1);
                        w_state_nxt = ST_ROW_START;
                    end
                end
                ST_ABORT_PEND: begin
                    if (w_wr_en) w_state_nxt = ST_IDLE;
                    else         w_q_vld_nxt = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_fmt       <= FMT_RGB565;
            r_q_vld     <= 1'b0;
            r_q_dat     <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_err_ovf   <= 1'b0;
            r_err_line  <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_fmt       <= w_fmt_nxt;
            r_q_vld     <= w_q_vld_nxt;
            r_q_dat     <= w_q_dat_nxt;
            r_err_ovf   <= (r_err_ovf   & ~cap.clear_errors) | w_set_ovf;
            r_err_line  <= (r_err_line  & ~cap.clear_errors) | w_set_line;
            r_err_frame <= (r_err_frame & ~cap.clear_errors) | w_set_frame;
            if (w_wr_en) begin
                if (r_q_dat == TOK_SOF) r_busy <= 1'b1;
                else if ((r_q_dat == TOK_EOF) || (r_q_dat == TOK_ABORT)) r_busy <= 1'b0;
                if (r_q_dat == TOK_EOF) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign cap.queue_clk    = PixelClk;
    assign cap.queue_data   = r_q_dat;
    assign cap.queue_wr_en  = w_wr_en;
    assign cap.frame_count  = r_frame_cnt;
    assign cap.err_overflow = r_err_ovf;
    assign cap.err_line     = r_err_line;
    assign cap.err_frame    = r_err_frame;
    assign cap.busy         = r_busy;
endmodule
